// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered RV32 branch-resolution stage.
// Selects operands (register file or forwarding buses), evaluates the
// conditional-branch condition, computes target / next PC, flags
// mispredictions and keeps saturating branch / mispredict statistics.
// After a mispredicting result leaves, younger branches are squashed
// until the frontend acknowledges the redirect with flush_in.
module branch_resolve_unit #(
  parameter  int XLEN    = 32,
  parameter  int NUM_FWD = 2,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = ($clog2(NUM_FWD + 1) > 1) ? $clog2(NUM_FWD + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst,

  // input side
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [XLEN-1:0]         in_rs1,
  input  logic [XLEN-1:0]         in_rs2,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [SEL_W-1:0]        op1_sel,
  input  logic [SEL_W-1:0]        op2_sel,
  input  logic [2:0]              funct3,
  input  logic                    pred_taken,
  input  logic                    flush_in,

  // output side
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_taken,
  output logic                    out_mispredict,
  output logic [XLEN-1:0]         out_target,
  output logic [XLEN-1:0]         out_next_pc,
  output logic                    out_misaligned,
  output logic                    out_illegal,

  // statistics
  output logic [CNT_W-1:0]        branch_count,
  output logic [CNT_W-1:0]        mispredict_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // --------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              taken_q, taken_d;
  logic              mispredict_q, mispredict_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN-1:0]   next_pc_q, next_pc_d;
  logic              misaligned_q, misaligned_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // --------------------------------------------------------------------
  // Forwarding slots unpacked into an array for readable selection
  // --------------------------------------------------------------------
  logic [XLEN-1:0] fwd_slot [NUM_FWD];

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_slot
      assign fwd_slot[gi] = fwd_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Operand selection: 0 -> register file, k -> slot k-1, out of range -> register file
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  always_comb begin
    op_a = in_rs1;
    op_b = in_rs2;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (op1_sel == SEL_W'(k + 1)) op_a = fwd_slot[k];
      if (op2_sel == SEL_W'(k + 1)) op_b = fwd_slot[k];
    end
  end

  // --------------------------------------------------------------------
  // Condition evaluation and address arithmetic for the incoming branch
  // --------------------------------------------------------------------
  logic            cond_taken;
  logic            cond_illegal;
  logic [XLEN-1:0] new_target;
  logic [XLEN-1:0] new_fallthru;
  logic [XLEN-1:0] new_next_pc;
  logic            new_misaligned;
  logic            new_mispredict;

  // Six RV32 branch conditions; the two unused encodings are never taken
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond_taken = (op_a == op_b);
      F3_BNE:  cond_taken = (op_a != op_b);
      F3_BLT:  cond_taken = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  cond_taken = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: cond_taken = (op_a <  op_b);
      F3_BGEU: cond_taken = (op_a >= op_b);
      default: cond_illegal = 1'b1;
    endcase
  end

  // Target and next-PC; sums wrap modulo 2^XLEN
  always_comb begin
    new_target     = in_pc + in_imm;
    new_fallthru   = in_pc + XLEN'(4);
    new_next_pc    = cond_taken ? new_target : new_fallthru;
    new_misaligned = cond_taken && (new_target[1:0] != 2'b00);
    new_mispredict = (cond_taken != pred_taken);
  end

  // --------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------
  logic in_hs;
  logic out_hs;
  logic load;

  // While squashing the stage swallows inputs, so it is always ready
  always_comb begin
    in_ready = (state_q == ST_SQUASH) || !out_valid_q || out_ready;
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid_q && out_ready;
    load     = in_hs && !flush_in && (state_q == ST_RUN);
  end

  // Next-state logic: flush wins, otherwise drain/load and enter squash on a leaving mispredict
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    if (flush_in) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
    end else begin
      if (out_hs)                 out_valid_d = 1'b0;
      if (load)                   out_valid_d = 1'b1;
      if (out_hs && mispredict_q) state_d     = ST_SQUASH;
    end
  end

  // Result payload only changes when a new branch is loaded
  always_comb begin
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    target_d     = target_q;
    next_pc_d    = next_pc_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    if (load) begin
      taken_d      = cond_taken;
      mispredict_d = new_mispredict;
      target_d     = new_target;
      next_pc_d    = new_next_pc;
      misaligned_d = new_misaligned;
      illegal_d    = cond_illegal;
    end
  end

  // Saturating statistics; an output handshake counts even during a flush
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (out_hs && (branch_cnt_q != {CNT_W{1'b1}}))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (out_hs && mispredict_q && (mispred_cnt_q != {CNT_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // All state: FSM, valid flag, result payload and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      target_q      <= '0;
      next_pc_q     <= '0;
      misaligned_q  <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      target_q      <= target_d;
      next_pc_q     <= next_pc_d;
      misaligned_q  <= misaligned_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Outputs straight from flops
  assign out_valid        = out_valid_q;
  assign out_taken        = taken_q;
  assign out_mispredict   = mispredict_q;
  assign out_target       = target_q;
  assign out_next_pc      = next_pc_q;
  assign out_misaligned   = misaligned_q;
  assign out_illegal      = illegal_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit. A second instance with
// 2-bit counters shares all inputs to exercise counter saturation.
module tb_branch_resolve_unit;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int SEL_W   = 2;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc, in_imm, in_rs1, in_rs2;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [SEL_W-1:0]        op1_sel, op2_sel;
  logic [2:0]              funct3;
  logic                    pred_taken;
  logic                    flush_in;
  logic                    out_valid, out_ready, out_taken, out_mispredict;
  logic [XLEN-1:0]         out_target, out_next_pc;
  logic                    out_misaligned, out_illegal;
  logic [15:0]             branch_count, mispredict_count;

  logic                    s_in_ready, s_out_valid, s_out_taken, s_out_mispredict;
  logic [XLEN-1:0]         s_out_target, s_out_next_pc;
  logic                    s_out_misaligned, s_out_illegal;
  logic [1:0]              s_branch_count, s_mispredict_count;

  int total;
  int bad;

  branch_resolve_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .fwd_data(fwd_data), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .funct3(funct3), .pred_taken(pred_taken), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_target(out_target), .out_next_pc(out_next_pc),
    .out_misaligned(out_misaligned), .out_illegal(out_illegal),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .fwd_data(fwd_data), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .funct3(funct3), .pred_taken(pred_taken), .flush_in(flush_in),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_taken(s_out_taken), .out_mispredict(s_out_mispredict),
    .out_target(s_out_target), .out_next_pc(s_out_next_pc),
    .out_misaligned(s_out_misaligned), .out_illegal(s_out_illegal),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // present one branch with in_valid high
  task automatic set_br(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [2:0] f3, input logic pred,
                        input logic [1:0] s1, input logic [1:0] s2);
    in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    funct3 = f3; pred_taken = pred; op1_sel = s1; op2_sel = s2;
    in_valid = 1'b1;
  endtask

  // advance one edge, then sample 1 time unit later
  task automatic step;
    @(posedge clk);
    #1;
    $display("txn t=%0t in_v=%0b in_rdy=%0b out_v=%0b tk=%0b mp=%0b ill=%0b mis=%0b tgt=%08h npc=%08h bc=%0d mc=%0d",
             $time, in_valid, in_ready, out_valid, out_taken, out_mispredict,
             out_illegal, out_misaligned, out_target, out_next_pc,
             branch_count, mispredict_count);
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    total++; if (out_target !== 32'd0 || out_next_pc !== 32'd0 || out_taken !== 1'b0) begin bad++; $display("FAIL reset_data got tgt=%08h npc=%08h tk=%0b exp=0", out_target, out_next_pc, out_taken); end
  endtask

  task automatic test_operand_select;
    fwd_data = {32'd5, 32'd7};
    // a = slot1 = 5, b = slot0 = 7, BEQ -> not taken
    set_br(32'h1000, 32'h40, 32'd0, 32'd0, 3'b000, 1'b0, 2'd2, 2'd1);
    step;
    total++; if (out_valid !== 1'b1 || out_taken !== 1'b0) begin bad++; $display("FAIL opsel_fwd v/tk got=%0b/%0b exp=1/0", out_valid, out_taken); end
    total++; if (out_next_pc !== 32'h1004) begin bad++; $display("FAIL opsel_fwd npc got=%08h exp=00001004", out_next_pc); end
    // sel 3 is out of range -> rs1 (7); b = slot0 = 7 -> taken
    set_br(32'h2000, 32'h40, 32'd7, 32'd0, 3'b000, 1'b1, 2'd3, 2'd1);
    step;
    total++; if (out_taken !== 1'b1 || out_next_pc !== 32'h2040) begin bad++; $display("FAIL opsel_rs1 tk/npc got=%0b/%08h exp=1/00002040", out_taken, out_next_pc); end
    in_valid = 1'b0;
    step;
    total++; if (out_valid !== 1'b0 || branch_count !== 16'd2) begin bad++; $display("FAIL opsel_drain v/bc got=%0b/%0d exp=0/2", out_valid, branch_count); end
    total++; if (s_branch_count !== 2'd2) begin bad++; $display("FAIL sat_pre bc got=%0d exp=2", s_branch_count); end
  endtask

  task automatic test_signed_unsigned;
    set_br(32'h3000, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_taken !== 1'b1) begin bad++; $display("FAIL blt got=%0b exp=1", out_taken); end
    set_br(32'h3000, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_taken !== 1'b0) begin bad++; $display("FAIL bltu got=%0b exp=0", out_taken); end
    set_br(32'h3000, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_taken !== 1'b0) begin bad++; $display("FAIL bge got=%0b exp=0", out_taken); end
    set_br(32'h3000, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_taken !== 1'b1 || out_next_pc !== 32'h3010) begin bad++; $display("FAIL bgeu tk/npc got=%0b/%08h exp=1/00003010", out_taken, out_next_pc); end
    set_br(32'h3000, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0) begin bad++; $display("FAIL illegal ill/tk/mp got=%0b/%0b/%0b exp=1/0/0", out_illegal, out_taken, out_mispredict); end
    in_valid = 1'b0;
    step;
    total++; if (branch_count !== 16'd7 || mispredict_count !== 16'd0) begin bad++; $display("FAIL signed_counts got=%0d/%0d exp=7/0", branch_count, mispredict_count); end
    total++; if (s_branch_count !== 2'd3) begin bad++; $display("FAIL sat_hold bc got=%0d exp=3", s_branch_count); end
  endtask

  task automatic test_targets;
    set_br(32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0, 3'b000, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_target !== 32'h4 || out_next_pc !== 32'h4 || out_misaligned !== 1'b0) begin bad++; $display("FAIL wrap_taken tgt/npc/mis got=%08h/%08h/%0b exp=4/4/0", out_target, out_next_pc, out_misaligned); end
    set_br(32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_target !== 32'h4 || out_next_pc !== 32'h0) begin bad++; $display("FAIL wrap_fall tgt/npc got=%08h/%08h exp=4/0", out_target, out_next_pc); end
    set_br(32'hFFFF_FFFC, 32'd2, 32'd0, 32'd0, 3'b000, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_misaligned !== 1'b1 || out_target !== 32'hFFFF_FFFE) begin bad++; $display("FAIL misaligned mis/tgt got=%0b/%08h exp=1/fffffffe", out_misaligned, out_target); end
    in_valid = 1'b0;
    step;
    total++; if (branch_count !== 16'd10) begin bad++; $display("FAIL targets_bc got=%0d exp=10", branch_count); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_br(32'h100, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b1 || out_next_pc !== 32'h104) begin bad++; $display("FAIL bp_load v/npc got=%0b/%08h exp=1/00000104", out_valid, out_next_pc); end
    set_br(32'h200, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      step;
      total++; if (out_valid !== 1'b1 || out_next_pc !== 32'h104) begin bad++; $display("FAIL bp_hold cyc=%0d v/npc got=%0b/%08h exp=1/00000104", i, out_valid, out_next_pc); end
    end
    out_ready = 1'b1;
    step;
    total++; if (out_next_pc !== 32'h204) begin bad++; $display("FAIL bp_b npc got=%08h exp=00000204", out_next_pc); end
    set_br(32'h300, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_next_pc !== 32'h304) begin bad++; $display("FAIL bp_c npc got=%08h exp=00000304", out_next_pc); end
    set_br(32'h400, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_next_pc !== 32'h404) begin bad++; $display("FAIL bp_d npc got=%08h exp=00000404", out_next_pc); end
    in_valid = 1'b0;
    step;
    total++; if (out_valid !== 1'b0 || branch_count !== 16'd14) begin bad++; $display("FAIL bp_count v/bc got=%0b/%0d exp=0/14", out_valid, branch_count); end
  endtask

  task automatic test_squash;
    // BEQ equal -> taken, predicted not taken -> mispredict
    set_br(32'h500, 32'h20, 32'd9, 32'd9, 3'b000, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_mispredict !== 1'b1 || out_next_pc !== 32'h520) begin bad++; $display("FAIL sq_mp mp/npc got=%0b/%08h exp=1/00000520", out_mispredict, out_next_pc); end
    in_valid = 1'b0;
    step;
    total++; if (out_valid !== 1'b0 || mispredict_count !== 16'd1) begin bad++; $display("FAIL sq_leave v/mc got=%0b/%0d exp=0/1", out_valid, mispredict_count); end
    for (int i = 0; i < 3; i++) begin
      set_br(32'h510 + 32'(i * 4), 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sq_in_ready cyc=%0d got=%0b exp=1", i, in_ready); end
      step;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sq_discard cyc=%0d v got=%0b exp=0", i, out_valid); end
    end
    in_valid = 1'b0;
    total++; if (branch_count !== 16'd15 || mispredict_count !== 16'd1) begin bad++; $display("FAIL sq_counts got=%0d/%0d exp=15/1", branch_count, mispredict_count); end
    flush_in = 1'b1;
    step;
    flush_in = 1'b0;
    set_br(32'h600, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b1 || out_next_pc !== 32'h604) begin bad++; $display("FAIL sq_resume v/npc got=%0b/%08h exp=1/00000604", out_valid, out_next_pc); end
    in_valid = 1'b0;
    step;
    total++; if (branch_count !== 16'd16) begin bad++; $display("FAIL sq_resume_bc got=%0d exp=16", branch_count); end
  endtask

  task automatic test_back_to_back;
    // BNE equal -> not taken, predicted taken -> mispredict
    set_br(32'h700, 32'h40, 32'd3, 32'd3, 3'b001, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_mispredict !== 1'b1 || out_next_pc !== 32'h704) begin bad++; $display("FAIL b2b_g mp/npc got=%0b/%08h exp=1/00000704", out_mispredict, out_next_pc); end
    // loaded on the same edge the mispredict leaves
    set_br(32'h800, 32'h10, 32'd3, 32'd3, 3'b000, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b1 || out_next_pc !== 32'h810 || out_mispredict !== 1'b0) begin bad++; $display("FAIL b2b_h v/npc/mp got=%0b/%08h/%0b exp=1/00000810/0", out_valid, out_next_pc, out_mispredict); end
    // now squashing: this one is dropped
    set_br(32'h900, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_squash v got=%0b exp=0", out_valid); end
    total++; if (branch_count !== 16'd18 || mispredict_count !== 16'd2) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=18/2", branch_count, mispredict_count); end
    total++; if (s_mispredict_count !== 2'd2 || s_branch_count !== 2'd3) begin bad++; $display("FAIL sat_counts got=%0d/%0d exp=3/2", s_branch_count, s_mispredict_count); end
    in_valid = 1'b0;
    flush_in = 1'b1;
    step;
    flush_in = 1'b0;
    set_br(32'hA00, 32'h0, 32'd0, 32'd0, 3'b001, 1'b0, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b1 || out_next_pc !== 32'hA04) begin bad++; $display("FAIL b2b_resume v/npc got=%0b/%08h exp=1/00000a04", out_valid, out_next_pc); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    set_br(32'hB00, 32'h8, 32'd0, 32'd0, 3'b000, 1'b1, 2'd0, 2'd0);
    step;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre v got=%0b exp=1", out_valid); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_next_pc !== 32'd0) begin bad++; $display("FAIL ar_valid v/npc got=%0b/%08h exp=0/0", out_valid, out_next_pc); end
    total++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0 || s_branch_count !== 2'd0) begin bad++; $display("FAIL ar_counts got=%0d/%0d/%0d exp=0/0/0", branch_count, mispredict_count, s_branch_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready got=%0b exp=1", in_ready); end
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    total++; if (out_valid !== 1'b0 || branch_count !== 16'd0) begin bad++; $display("FAIL ar_after v/bc got=%0b/%0d exp=0/0", out_valid, branch_count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
    fwd_data = '0; op1_sel = '0; op2_sel = '0; funct3 = '0;
    pred_taken = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #2;
    test_reset;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    test_operand_select;
    test_signed_unsigned;
    test_targets;
    test_backpressure;
    test_squash;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch-resolution stage for the RV32 pipeline. Per branch it:
- selects each operand from the architectural register value or one of `NUM_FWD` forwarding buses;
- evaluates all six RV32 conditional-branch conditions;
- computes target and next PC;
- flags mispredictions against the frontend's prediction.

It sits between decode/register-read and the frontend redirect logic. Handshakes are valid/ready on both sides. A wrong-path squash state discards younger branches until the frontend acknowledges the redirect. Saturating counters provide branch and mispredict statistics.

## Interface
- `XLEN`, 32, datapath width
- `NUM_FWD`, 2, number of forwarding sources (≥1)
- `CNT_W`, 16, statistics counter width
- Derived: `SEL_W` = max(1, clog2(NUM_FWD+1))

Clock and reset (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset

Input side:
- `in_valid`  in  1  branch presented
- `in_ready`  out  1  stage can accept
- `in_pc`  in  XLEN  branch PC
- `in_imm`  in  XLEN  sign-extended B-immediate
- `in_rs1`, `in_rs2`  in  XLEN  register-file operands
- `fwd_data`  in  NUM_FWD*XLEN  forwarding buses; slot k at bits [k*XLEN +: XLEN]
- `op1_sel`, `op2_sel`  in  SEL_W  operand select
  - 0 = rs
  - k = slot k-1
  - any value > NUM_FWD = rs
- `funct3`  in  3  branch condition
- `pred_taken`  in  1  frontend prediction
- `flush_in`  in  1  redirect acknowledged / pipeline flush

Output side:
- `out_valid`  out  1  resolved result held
- `out_ready`  in  1  consumer accepts
- `out_taken`  out  1  condition true
- `out_mispredict`  out  1  out_taken != registered pred_taken
- `out_target`  out  XLEN  pc + imm
- `out_next_pc`  out  XLEN  out_taken ? target : pc + 4
- `out_misaligned`  out  1  taken and target[1:0] != 0
- `out_illegal`  out  1  funct3 ∈ {010, 011}

Statistics:
- `branch_count`  out  CNT_W  accepted outputs, saturating
- `mispredict_count`  out  CNT_W  accepted mispredicting outputs, saturating

## Operation
Condition evaluation uses the selected operands a, b:
- 000 BEQ: a == b
- 001 BNE: a != b
- 100 BLT: signed a < b
- 101 BGE: signed a ≥ b
- 110 BLTU: unsigned a < b
- 111 BGEU: unsigned a ≥ b
- 010, 011: not taken, `out_illegal` = 1, `out_mispredict` = `pred_taken`

Arithmetic: all sums are modulo 2^XLEN; carry is discarded.

State machine with two states, RUN and SQUASH.

RUN:
- `in_ready` = !out_valid || out_ready.
- An input handshake loads the result register.
- An output handshake with `out_mispredict` = 1 → SQUASH.

SQUASH:
- `in_ready` = 1.
- Input handshakes are consumed and discarded; no output is produced and counters are unchanged.
- `out_valid` is 0 once the mispredicting result leaves.

`flush_in`:
- Applies in either state and has priority over everything else.
- Clears `out_valid`.
- Discards any same-cycle input.
- Next state is RUN.
- A same-cycle output handshake still counts.

Counters:
- `branch_count` +1 on each output handshake.
- `mispredict_count` +1 on each output handshake with `out_mispredict` = 1.
- Both hold at 2^CNT_W − 1.
- Both clear only on `rst`.

## Timing
- Latency: an input accepted at edge N gives its result on `out_valid`/data after edge N.
- Throughput: one branch per cycle when `out_ready` = 1.
- Data outputs are registered and change only on load; they hold while `out_valid` && !out_ready.
- `in_ready` is combinational from `out_valid`, `out_ready` and state.
- Reset values: state RUN; `out_valid` 0; all data outputs 0; both counters 0; `in_ready` 1.
- Reset mid-operation drops the held result with no counter update.
- Simultaneous output handshake and new input in RUN: the new result loads the same edge (back-to-back).
  - If the leaving result mispredicts, the same-edge input is still loaded. It is the one op that left decode before the redirect, and the consumer discards it.
  - SQUASH begins on the next edge.

## Test plan
- Operand select:
  - `fwd_data` slot1 = 5, slot0 = 7; `op1_sel` = 2, `op2_sel` = 1, `funct3` = 000. Expect BEQ not taken.
  - `op1_sel` = 3 selects `in_rs1`.
- Signed vs unsigned: a = 0xFFFF_FFFF, b = 1. Expect BLT taken, BLTU not taken, BGE not taken, BGEU taken. Also `funct3` = 010 → `out_illegal` = 1, not taken.
- Targets:
  - pc = 0xFFFF_FFFC, imm = 8, taken → `out_target` = 0x0000_0004.
  - Same, not taken → `out_next_pc` = 0x0000_0000.
  - imm = 2, taken → `out_misaligned` = 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1. Expect `in_ready` = 0 and outputs stable. Releasing gives one result per cycle and `branch_count` +4 after 4 ops.
- Squash: a mispredicting branch handshakes, then 3 inputs arrive. Expect all consumed with no `out_valid`. `flush_in` returns to RUN; the next input appears after 1 cycle. `mispredict_count` = 1.
- Saturation and reset: with `CNT_W` = 2, 5 handshakes → `branch_count` = 3. Assert `rst` asynchronously mid-cycle → `out_valid` and counters go to 0 before the next edge.
